// File: rtl/hv_chunk_feeder.sv
// hv_chunk_feeder: holds the query HV and streams class-HV chunks from a
// synchronous-read class memory to the partial_dot consumer. One chunk is
// kept prefetched so class_hv advances on the same edge that samples a strobe.
module hv_chunk_feeder #(
  parameter int WIDTH  = 256,
  parameter int CENT_W = 16,
  parameter int D      = 256,
  parameter int NUM_C  = 10,
  parameter int ADDR_W = $clog2(NUM_C * (D / (WIDTH / CENT_W))),
  parameter int CL_W   = $clog2(NUM_C)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prime,
  input  logic [WIDTH-1:0]  in_hv_i,
  input  logic              next_cent,
  input  logic              next_class,
  input  logic              pd_done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  in_hv,
  output logic [WIDTH-1:0]  class_hv,
  output logic [CL_W-1:0]   class_L,
  output logic              ready,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int GROUPS = WIDTH / CENT_W;
  localparam int CHUNKS = D / GROUPS;
  localparam int DEPTH  = NUM_C * CHUNKS;
  localparam int CH_W   = $clog2(CHUNKS);

  // Strobe protocol: next_cent / next_class are single-cycle requests sampled
  // on the rising edge. A request is accepted only in STREAM with a prefetched
  // chunk available (pf_valid) and a legal chunk/class position; the new chunk
  // is on class_hv right after that edge. Anything else sets the sticky err
  // and is otherwise ignored. ready marks that the consumer may start issuing.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL0  = 3'd1,
    FILL1  = 3'd2,
    FILL2  = 3'd3,
    STREAM = 3'd4
  } state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    in_hv_d, class_hv_d, pf, pf_d;
  logic                pf_valid, pf_valid_d;
  logic                rd_q, rd_q_d;
  logic [CH_W-1:0]     chunk, chunk_d;
  logic [CL_W-1:0]     class_d;
  logic                mem_en_d, ready_d, err_d;
  logic [ADDR_W-1:0]   mem_addr_d;

  logic                strobe, cent_ok, class_ok;
  logic [CH_W-1:0]     adv_chunk;
  logic [CL_W-1:0]     adv_class;
  logic [ADDR_W:0]     lin_next;

  assign dbg_state = state;

  // Strobe legality and the address of the chunk after the one being advanced to.
  always_comb begin
    strobe    = next_cent | next_class;
    cent_ok   = next_cent && !next_class && pf_valid && (chunk != CH_W'(CHUNKS - 1));
    class_ok  = next_class && !next_cent && pf_valid && (chunk == CH_W'(CHUNKS - 1))
                && (class_L != CL_W'(NUM_C - 1));
    adv_chunk = class_ok ? '0 : chunk + CH_W'(1);
    adv_class = class_ok ? class_L + CL_W'(1) : class_L;
    // Linear address order: next prefetch is simply current linear index + 1.
    lin_next  = (ADDR_W+1)'(adv_class) * (ADDR_W+1)'(CHUNKS)
              + (ADDR_W+1)'(adv_chunk) + (ADDR_W+1)'(1);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state;
    in_hv_d    = in_hv;
    class_hv_d = class_hv;
    pf_d       = pf;
    pf_valid_d = pf_valid;
    rd_q_d     = 1'b0;
    chunk_d    = chunk;
    class_d    = class_L;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr;
    ready_d    = ready;
    err_d      = err;
    case (state)
      IDLE: begin
        if (prime) begin
          in_hv_d    = in_hv_i;
          err_d      = 1'b0;
          chunk_d    = '0;
          class_d    = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = '0;
          state_d    = FILL0;
        end
        if (strobe) err_d = 1'b1;
      end
      FILL0: begin
        mem_en_d   = 1'b1;
        mem_addr_d = ADDR_W'(1);
        state_d    = FILL1;
        if (strobe) err_d = 1'b1;
      end
      FILL1: begin
        class_hv_d = mem_rdata;
        state_d    = FILL2;
        if (strobe) err_d = 1'b1;
      end
      FILL2: begin
        pf_d       = mem_rdata;
        pf_valid_d = 1'b1;
        ready_d    = 1'b1;
        state_d    = STREAM;
        if (strobe) err_d = 1'b1;
      end
      STREAM: begin
        if (pd_done) begin
          ready_d    = 1'b0;
          pf_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          // Read issued on the previous edge: data is on mem_rdata now.
          rd_q_d = mem_en;
          if (rd_q) begin
            pf_d       = mem_rdata;
            pf_valid_d = 1'b1;
          end
          if (cent_ok || class_ok) begin
            class_hv_d = pf;
            pf_valid_d = 1'b0;
            chunk_d    = adv_chunk;
            class_d    = adv_class;
            if (lin_next < (ADDR_W+1)'(DEPTH)) begin
              mem_en_d   = 1'b1;
              mem_addr_d = lin_next[ADDR_W-1:0];
            end
          end else if (strobe) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_hv    <= '0;
      class_hv <= '0;
      pf       <= '0;
      pf_valid <= 1'b0;
      rd_q     <= 1'b0;
      chunk    <= '0;
      class_L  <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      in_hv    <= in_hv_d;
      class_hv <= class_hv_d;
      pf       <= pf_d;
      pf_valid <= pf_valid_d;
      rd_q     <= rd_q_d;
      chunk    <= chunk_d;
      class_L  <= class_d;
      mem_en   <= mem_en_d;
      mem_addr <= mem_addr_d;
      ready    <= ready_d;
      err      <= err_d;
    end
  end

endmodule
